// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned IF_W       = 32;
  localparam int unsigned SIZE_W     = 3;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY_IF = 2'b01,
    ST_BUSY_LS = 2'b10,
    ST_RESP    = 2'b11
  } arb_state_e;

  // Grant encoding, shared by grant_r and rr_last
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  // Instruction fetches are always 32-bit reads
  localparam logic [SIZE_W-1:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and load/store.
// Build option: MEM_ARB_RR_EN selects round-robin on contention instead of fixed LS priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic ls_req,
  input  logic rr_last,
  output logic grant,
  output logic valid
);

`ifdef MEM_ARB_RR_EN
  // Contention goes to whoever was not granted last; a lone requester always wins
  always_comb begin
    valid = if_req | ls_req;
    grant = GNT_IF;
    if (if_req && ls_req) begin
      grant = (rr_last == GNT_IF) ? GNT_LS : GNT_IF;
    end else if (ls_req) begin
      grant = GNT_LS;
    end
  end
`else
  // Fixed priority: load/store beats fetch; history is not needed
  logic unused_rr_last;
  assign unused_rr_last = rr_last;

  always_comb begin
    valid = if_req | ls_req;
    grant = GNT_IF;
    if (ls_req) begin
      grant = GNT_LS;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and the load/store FSM.
// Build option: MEM_ARB_RR_EN (round-robin on simultaneous requests, see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_start,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [IF_W-1:0]   if_rdata,
  input  logic              ls_start,
  input  logic              ls_write,
  input  logic [SIZE_W-1:0] ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_start,
  output logic              mem_write,
  output logic [SIZE_W-1:0] mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              rr_last_q, rr_last_d;
  logic              cmd_write_q, cmd_write_d;
  logic [SIZE_W-1:0] cmd_size_q, cmd_size_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [IF_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  logic              mem_start_q, mem_start_d;

  logic              pick_grant;
  logic              pick_valid;

  mem_arb_pick u_pick (
    .if_req  (if_start),
    .ls_req  (ls_start),
    .rr_last (rr_last_q),
    .grant   (pick_grant),
    .valid   (pick_valid)
  );

  // Next-state, command latch, read-data capture and done generation
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_last_d   = rr_last_q;
    cmd_write_d = cmd_write_q;
    cmd_size_d  = cmd_size_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    mem_start_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d     = pick_grant;
          rr_last_d   = pick_grant;
          mem_start_d = 1'b1;
          if (pick_grant == GNT_LS) begin
            cmd_write_d = ls_write;
            cmd_size_d  = ls_size;
            cmd_addr_d  = ls_addr;
            cmd_wdata_d = ls_wdata;
            state_d     = ST_BUSY_LS;
          end else begin
            cmd_write_d = 1'b0;
            cmd_size_d  = SIZE_WORD;
            cmd_addr_d  = if_addr;
            cmd_wdata_d = '0;
            state_d     = ST_BUSY_IF;
          end
        end
      end

      ST_BUSY_IF: begin
        mem_start_d = 1'b1;
        if (mem_done) begin
          if_rdata_d  = mem_rdata[IF_W-1:0];
          if_done_d   = 1'b1;
          mem_start_d = 1'b0;
          state_d     = ST_RESP;
        end
      end

      ST_BUSY_LS: begin
        mem_start_d = 1'b1;
        if (mem_done) begin
          if (!cmd_write_q) begin
            ls_rdata_d = mem_rdata;
          end
          ls_done_d   = 1'b1;
          mem_start_d = 1'b0;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous active-low reset aborts any transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_IF;
      rr_last_q   <= GNT_IF;
      cmd_write_q <= 1'b0;
      cmd_size_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      mem_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_last_q   <= rr_last_d;
      cmd_write_q <= cmd_write_d;
      cmd_size_q  <= cmd_size_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      mem_start_q <= mem_start_d;
    end
  end

  // Memory port is driven only from latched command state
  assign mem_start = mem_start_q;
  assign mem_write = cmd_write_q;
  assign mem_size  = cmd_size_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign ls_done   = ls_done_q;
  assign ls_rdata  = ls_rdata_q;

endmodule
